// File: rtl/dram_ctrl_pkg.sv
// Shared widths, FSM encoding and packed address layout
// for the DRAM request arbiter.
package dram_ctrl_pkg;

    localparam int DRAM_BANKS = 8;
    localparam int DRAM_ROWS  = 128;
    localparam int DRAM_COLS  = 8;

    localparam int BW = $clog2(DRAM_BANKS);
    localparam int RW = $clog2(DRAM_ROWS);
    localparam int CW = $clog2(DRAM_COLS);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARB   = 2'b01,
        ISSUE = 2'b10,
        WAIT  = 2'b11
    } arb_state_e;

    typedef struct packed {
        logic [BW-1:0] bank;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } dram_addr_t;

    function automatic dram_addr_t mk_addr(input int b, input int r, input int c);
        dram_addr_t a;
        a.bank = BW'(b);
        a.row  = RW'(r);
        a.col  = CW'(c);
        return a;
    endfunction

endpackage

// File: rtl/dram_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N; reports one-hot and index of the winner.
module dram_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          vld_o,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic [IW-1:0] j;
        vld_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!vld_o && req_i[j]) begin
                vld_o = 1'b1;
                idx_o = j;
            end
        end
        gnt_o[idx_o] = vld_o;
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one DRAM controller port.
// Define DRAM_ARB_ROW_HIT_EN to add the open-row table and row-hit tier.
module dram_req_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter  int NUM_REQ         = 4,
    parameter  int NUMBER_OF_BANKS = DRAM_BANKS,
    parameter  int NUMBER_OF_ROWS  = DRAM_ROWS,
    parameter  int NUMBER_OF_COLS  = DRAM_COLS,
    parameter  int STARVE_LIMIT    = 15,
    localparam int BANK_W = $clog2(NUMBER_OF_BANKS),
    localparam int ROW_W  = $clog2(NUMBER_OF_ROWS),
    localparam int COL_W  = $clog2(NUMBER_OF_COLS),
    localparam int IW     = $clog2(NUM_REQ),
    localparam int AW     = BANK_W + ROW_W + COL_W
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_REQ-1:0]    req_val,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    req_rdy,
    input  logic                  refresh_flag,
    input  logic                  ctrl_rdy,
    input  logic                  ctrl_done,
    output logic                  addr_val,
    output logic [BANK_W-1:0]     bank_id,
    output logic [ROW_W-1:0]      row_id,
    output logic [COL_W-1:0]      col_id,
    output logic [IW-1:0]         grant_id,
    output logic                  row_hit
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_e state_q, state_d;

    logic              grant_en;
    logic              accept;
    logic [IW-1:0]     rr_q;
    logic [IW-1:0]     gid_q;
    logic [BANK_W-1:0] bank_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [SW-1:0]     cnt_q [NUM_REQ];

    logic [BANK_W-1:0] bank_w [NUM_REQ];
    logic [ROW_W-1:0]  row_w  [NUM_REQ];
    logic [COL_W-1:0]  col_w  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign {bank_w[g], row_w[g], col_w[g]} = req_addr[g*AW +: AW];
    end

    logic [NUM_REQ-1:0] st_mask;
    logic               st_vld, all_vld;
    logic [NUM_REQ-1:0] st_gnt, all_gnt;
    logic [IW-1:0]      st_idx, all_idx;

    always_comb begin
        st_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            st_mask[i] = req_val[i] && (cnt_q[i] >= LIMIT);
        end
    end

    dram_rr_pick #(.N(NUM_REQ)) u_pick_starve (
        .req_i (st_mask),
        .ptr_i (rr_q),
        .vld_o (st_vld),
        .gnt_o (st_gnt),
        .idx_o (st_idx)
    );

    dram_rr_pick #(.N(NUM_REQ)) u_pick_all (
        .req_i (req_val),
        .ptr_i (rr_q),
        .vld_o (all_vld),
        .gnt_o (all_gnt),
        .idx_o (all_idx)
    );

    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] win_oh;

`ifdef DRAM_ARB_ROW_HIT_EN
    logic [NUMBER_OF_BANKS-1:0] ort_vld_q;
    logic [ROW_W-1:0]           ort_row_q [NUMBER_OF_BANKS];
    logic [NUM_REQ-1:0]         hit_mask;
    logic                       hit_vld;
    logic [NUM_REQ-1:0]         hit_gnt;
    logic [IW-1:0]              hit_idx;
    logic                       hit_q;

    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_mask[i] = req_val[i] && ort_vld_q[bank_w[i]]
                       && (ort_row_q[bank_w[i]] == row_w[i]);
        end
    end

    dram_rr_pick #(.N(NUM_REQ)) u_pick_hit (
        .req_i (hit_mask),
        .ptr_i (rr_q),
        .vld_o (hit_vld),
        .gnt_o (hit_gnt),
        .idx_o (hit_idx)
    );

    always_comb begin
        win_idx = all_idx;
        win_oh  = all_gnt;
        if (st_vld) begin
            win_idx = st_idx;
            win_oh  = st_gnt;
        end else if (hit_vld) begin
            win_idx = hit_idx;
            win_oh  = hit_gnt;
        end
    end

    // Refresh precharges every bank, so the whole table goes stale.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            ort_vld_q <= '0;
            for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
                ort_row_q[b] <= '0;
            end
        end else if (refresh_flag) begin
            ort_vld_q <= '0;
        end else if (accept) begin
            ort_vld_q[bank_q] <= 1'b1;
            ort_row_q[bank_q] <= row_q;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            hit_q <= 1'b0;
        end else if (grant_en) begin
            hit_q <= hit_mask[win_idx];
        end
    end

    assign row_hit = hit_q;
`else
    always_comb begin
        win_idx = all_idx;
        win_oh  = all_gnt;
        if (st_vld) begin
            win_idx = st_idx;
            win_oh  = st_gnt;
        end
    end

    assign row_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        accept   = 1'b0;
        addr_val = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (all_vld && !refresh_flag) state_d = ARB;
            end
            ARB: begin
                if (!all_vld) begin
                    state_d = IDLE;
                end else if (!refresh_flag) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                addr_val = !refresh_flag;
                if (addr_val && ctrl_rdy) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ctrl_done) state_d = all_vld ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant fields freeze from ARB exit until the next grant.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                gid_q  <= win_idx;
                bank_q <= bank_w[win_idx];
                row_q  <= row_w[win_idx];
                col_q  <= col_w[win_idx];
                rr_q   <= (win_idx == IW'(NUM_REQ - 1))
                        ? '0 : win_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (grant_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_val[i] || win_oh[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != LIMIT) begin
                    cnt_q[i] <= cnt_q[i] + SW'(1);
                end
            end
        end
    end

    assign req_rdy  = accept ? (NUM_REQ'(1) << gid_q) : '0;
    assign grant_id = gid_q;
    assign bank_id  = bank_q;
    assign row_id   = row_q;
    assign col_id   = col_q;

endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares one DRAM controller FSM among NUM_REQ requesters (e.g. CPU port, DMA, debug).
- Holds an open-row table per bank and prefers requests that hit the open row, using round-robin order with a starvation guard.
- Drives addr_val/bank_id/row_id/col_id into the controller FSM.
- Stops issuing while refresh_flag is high.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- NUMBER_OF_BANKS, 8, banks; BW = $clog2(NUMBER_OF_BANKS)
- NUMBER_OF_ROWS, 128, rows per bank; RW = $clog2(NUMBER_OF_ROWS)
- NUMBER_OF_COLS, 8, columns per row; CW = $clog2(NUMBER_OF_COLS)
- STARVE_LIMIT, 15, number of passed-over arbitrations after which a requester is forced to win

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-high
- req_val  in  NUM_REQ  per-requester request valid; held until accepted
- req_addr  in  NUM_REQ*(BW+RW+CW)  packed {bank,row,col} per requester; requester i at slice i
- req_rdy  out  NUM_REQ  one-hot, 1-cycle accept pulse to the granted requester
- refresh_flag  in  1  refresh in progress; blocks issue
- ctrl_rdy  in  1  controller can take a new address this cycle
- ctrl_done  in  1  1-cycle pulse, current access complete
- addr_val  out  1  address valid to controller
- bank_id  out  BW  granted bank
- row_id  out  RW  granted row
- col_id  out  CW  granted column
- grant_id  out  $clog2(NUM_REQ)  index of the current grantee
- row_hit  out  1  granted request hits the open row

Behaviour:
- Reset (rst_b=1, asynchronous): state=IDLE; all outputs 0; rr_ptr=0; starvation counters 0; open-row valid bits 0. A reset mid-access abandons the access; no req_rdy is issued for it.
- FSM states: IDLE, ARB, ISSUE, WAIT.
- IDLE: go to ARB if |req_val and !refresh_flag.
- ARB: compute the winner (see selection) and register it into grant_id, bank_id/row_id/col_id and row_hit; go to ISSUE. If refresh_flag=1, or req_val is all zero, stay in ARB or return to IDLE (req_val all zero gives IDLE) and register no grant.
- ISSUE: addr_val=1 while !refresh_flag; addr_val=0 for every cycle refresh_flag=1, and the grant is held.
  - Accept = addr_val & ctrl_rdy. On accept: req_rdy[grant_id]=1 for exactly that cycle; write the open-row table entry[bank_id]={valid=1,row=row_id}; go to WAIT.
- WAIT: addr_val=0. On ctrl_done: go to ARB if |req_val, else IDLE.
- Minimum latency: req_val seen in IDLE at cycle 0, addr_val=1 at cycle 2; req_rdy pulses in the cycle ctrl_rdy is first seen in ISSUE.
- Selection, combinational in ARB, in priority order:
  1. Any requester with starve_cnt >= STARVE_LIMIT; if several, round-robin from rr_ptr.
  2. Row-hit requesters (open-row entry for its bank has valid=1 and row equal to its row), round-robin from rr_ptr.
  3. All valid requesters, round-robin from rr_ptr.
- Round-robin update: on each grant, rr_ptr = grant_id+1, wrapping modulo NUM_REQ.
- Starvation counters, on each grant:
  - every requester with req_val=1 that was not granted increments its count, saturating at STARVE_LIMIT;
  - the grantee's count clears;
  - a requester with req_val=0 clears its count.
- Open-row table: every cycle with refresh_flag=1 clears all valid bits, since refresh precharges all banks. Refresh and accept cannot coincide, because addr_val is 0 during refresh.
- req_val dropped by the grantee while in ISSUE is a protocol violation; the grant is still held until accept.
- The grant is frozen from ARB exit until accept, so outputs are stable while addr_val=1.

Optional Feature:
- Macro: DRAM_ARB_ROW_HIT_EN.
- Defined: open-row table, row-hit priority tier 2, and the row_hit output are all present.
- Undefined: no open-row table; selection is starvation tier then plain round-robin; row_hit is tied to 0. Starvation logic stays.

Decomposition:
- Package dram_ctrl_pkg holds:
  - width constants BW/RW/CW, derived from the shared NUMBER_OF_* defaults;
  - the FSM state encoding (IDLE=2'b00, ARB=2'b01, ISSUE=2'b10, WAIT=2'b11);
  - the packed address struct {bank,row,col}.
- Sub-module dram_rr_pick: combinational round-robin picker. Inputs are a NUM_REQ request mask and rr_ptr; outputs are valid and a one-hot/index winner. It is instantiated once per priority tier.

Test Plan:
- Single request: req_val=4'b0001, addr {bank 2,row 5,col 3}, ctrl_rdy=1 -> addr_val=1 at cycle 2 with bank_id=2,row_id=5,col_id=3; req_rdy=4'b0001 for 1 cycle; ctrl_done returns FSM to IDLE.
- Round-robin: all four requesters are valid with distinct banks, no hits, ctrl_done 3 cycles after accept -> grant order 0,1,2,3,0.
- Row-hit priority (macro defined): table holds bank 1 row 9 open; req0={1,40,0}, req2={1,9,4}, rr_ptr=0 -> grant_id=2, row_hit=1. With the macro undefined -> grant_id=0, row_hit=0.
- Starvation with STARVE_LIMIT=3: req3 keeps missing the row while req0 keeps hitting -> req3 granted on its 4th arbitration; its counter reads 0 afterwards.
- Refresh during ISSUE: refresh_flag=1 for 5 cycles -> addr_val=0 for those 5 cycles, grant unchanged, table valid bits cleared; addr_val=1 again the cycle after refresh_flag falls.
- Async reset in WAIT: assert rst_b mid-cycle -> all outputs 0 immediately, no req_rdy pulse; after release, pending requests are re-arbitrated starting from rr_ptr=0.
